// File: rtl/task_dispatcher_pkg.sv
// Shared definitions for the task dispatcher: message kinds, fence codes,
// header field positions and FSM state encoding.
package gpu_def;

    typedef enum logic [1:0] {
        KIND_CMASK  = 2'd0,
        KIND_R0MASK = 2'd1,
        KIND_R0DATA = 2'd2,
        KIND_INSTR  = 2'd3
    } msg_kind_e;

    typedef enum logic [1:0] {
        FENCE_NONE  = 2'b00,
        FENCE_ACQ   = 2'b01,
        FENCE_REL   = 2'b10,
        FENCE_NONE3 = 2'b11
    } fence_e;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT, S_CMASK, S_R0MASK, S_R0DATA, S_INSTR, S_DRAIN, S_DONE
    } state_t;

    localparam int IFNUM_SHIFT = 0;
    localparam int FENCE_SHIFT = 6;
    localparam int FENCE_W     = 2;

    // End-of-program flag sits in the MSB of the header word, whatever its width.
    function automatic logic hdr_end(input logic [31:0] hdr, input int w);
        return hdr[w-1];
    endfunction

endpackage

// File: rtl/task_dispatcher_if.sv
// Core message bus: dispatcher (master) pushes words, core side (slave) accepts.
interface task_dispatcher_if #(parameter int INSTR_W = 16);
    logic               msg_valid;
    logic               msg_ready;
    logic [INSTR_W-1:0] msg_data;
    logic [1:0]         msg_kind;
    logic               msg_last;

    modport master (output msg_valid, msg_data, msg_kind, msg_last, input msg_ready);
    modport slave  (input msg_valid, msg_data, msg_kind, msg_last, output msg_ready);
endinterface

// File: rtl/task_dispatcher_prog_mem.sv
// Program storage: one synchronous write port, one combinational read port.
module prog_mem #(
    parameter int MEM_DEPTH = 1024,
    parameter int INSTR_W   = 16
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_DEPTH)-1:0] waddr,
    input  logic [INSTR_W-1:0]           wdata,
    input  logic [$clog2(MEM_DEPTH)-1:0] raddr,
    output logic [INSTR_W-1:0]           rdata
);
    logic [INSTR_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/task_dispatcher.sv
// Walks task headers in program memory and streams core mask, r0 mask, r0 data
// and instruction frames onto the core bus, honouring ACQ/REL fences.
module task_dispatcher
    import gpu_def::*;
#(
    parameter int INSTR_W     = 16,
    parameter int MEM_DEPTH   = 1024,
    parameter int CORE_NUM    = 16,
    parameter int FRAME_WORDS = 16,
    parameter int IFNUM_W     = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         prog_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] prog_addr,
    input  logic [INSTR_W-1:0]           prog_wdata,
    input  logic                         start,
    input  logic [$clog2(MEM_DEPTH)-1:0] start_addr,
    input  logic [CORE_NUM-1:0]          core_busy,
    task_dispatcher_if.master            bus,
    output logic                         busy,
    output logic                         prog_done
);
    localparam int AW  = $clog2(MEM_DEPTH);
    localparam int WW  = $clog2(FRAME_WORDS);
    localparam int NRD = 3;
    localparam logic [WW-1:0] WLAST = WW'(FRAME_WORDS - 1);

    state_t               state;
    logic [AW-1:0]        base, ptr;
    logic [IFNUM_W-1:0]   if_num, fcnt;
    fence_e               fence;
    logic [INSTR_W-1:0]   cmask, r0mask;
    logic [WW-1:0]        wcnt;
    logic                 vld, last;
    logic [INSTR_W-1:0]   data;
    msg_kind_e            kind;

    // Three identical banks so the header, core mask and r0 mask land in one cycle.
    logic [NRD-1:0][AW-1:0]      rd_addr;
    logic [NRD-1:0][INSTR_W-1:0] rd_data;
    logic                        wr_en;

    assign wr_en = prog_we & ~busy;

    always_comb begin
        rd_addr[0] = (state == S_FETCH) ? base : ptr;
        rd_addr[1] = base + AW'(1);
        rd_addr[2] = base + AW'(2);
    end

    for (genvar g = 0; g < NRD; g++) begin : g_bank
        prog_mem #(.MEM_DEPTH(MEM_DEPTH), .INSTR_W(INSTR_W)) u_mem (
            .clk   (clk),
            .we    (wr_en),
            .waddr (prog_addr),
            .wdata (prog_wdata),
            .raddr (rd_addr[g]),
            .rdata (rd_data[g])
        );
    end

    logic          wait_ok, drain_ok, at_end;
    logic [AW-1:0] next_base;

    always_comb begin
        drain_ok  = (cmask[CORE_NUM-1:0] & core_busy) == '0;
        wait_ok   = drain_ok && (fence != FENCE_REL || core_busy == '0);
        at_end    = (wcnt == WLAST) &&
                    ((state == S_R0DATA && if_num == '0) ||
                     (state == S_INSTR  && fcnt == if_num - IFNUM_W'(1)));
        next_base = base + AW'((32'(if_num) + 32'd1) * FRAME_WORDS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            base      <= '0;
            ptr       <= '0;
            if_num    <= '0;
            fcnt      <= '0;
            fence     <= FENCE_NONE;
            cmask     <= '0;
            r0mask    <= '0;
            wcnt      <= '0;
            vld       <= 1'b0;
            last      <= 1'b0;
            data      <= '0;
            kind      <= KIND_CMASK;
            busy      <= 1'b0;
            prog_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    base  <= start_addr;
                    busy  <= 1'b1;
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    if_num <= rd_data[0][IFNUM_SHIFT +: IFNUM_W];
                    fence  <= fence_e'(rd_data[0][FENCE_SHIFT +: FENCE_W]);
                    cmask  <= rd_data[1];
                    r0mask <= rd_data[2];
                    if (hdr_end(32'(rd_data[0]), INSTR_W)) begin
                        prog_done <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: if (wait_ok) begin
                    vld   <= 1'b1;
                    data  <= cmask;
                    kind  <= KIND_CMASK;
                    last  <= 1'b0;
                    ptr   <= base + AW'(3);
                    state <= S_CMASK;
                end
                S_CMASK: if (bus.msg_ready) begin
                    data  <= r0mask;
                    kind  <= KIND_R0MASK;
                    state <= S_R0MASK;
                end
                S_R0MASK: if (bus.msg_ready) begin
                    data  <= rd_data[0];
                    ptr   <= ptr + AW'(1);
                    kind  <= KIND_R0DATA;
                    wcnt  <= WW'(3);
                    last  <= (WW'(3) == WLAST);
                    state <= S_R0DATA;
                end
                S_R0DATA, S_INSTR: if (bus.msg_ready) begin
                    if (at_end) begin
                        vld   <= 1'b0;
                        last  <= 1'b0;
                        base  <= next_base;
                        state <= (fence == FENCE_ACQ) ? S_DRAIN : S_FETCH;
                    end else begin
                        data <= rd_data[0];
                        ptr  <= ptr + AW'(1);
                        if (wcnt == WLAST) begin
                            // Frame boundary: r0 data rolls into the first instruction frame.
                            wcnt  <= '0;
                            fcnt  <= (state == S_INSTR) ? fcnt + IFNUM_W'(1) : '0;
                            kind  <= KIND_INSTR;
                            last  <= 1'b0;
                            state <= S_INSTR;
                        end else begin
                            wcnt <= wcnt + WW'(1);
                            last <= (wcnt + WW'(1) == WLAST);
                        end
                    end
                end
                S_DRAIN: if (drain_ok) state <= S_FETCH;
                S_DONE: begin
                    prog_done <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.msg_valid = vld;
    assign bus.msg_data  = data;
    assign bus.msg_kind  = kind;
    assign bus.msg_last  = last;
endmodule

// File: tb/tb_task_dispatcher.sv
// Directed bench for task_dispatcher: latency, stalls, fences, wrap and reset.
module tb_task_dispatcher;
    localparam int MD = 1024;

    logic        clk = 1'b0, reset = 1'b1, prog_we = 1'b0, start = 1'b0;
    logic [9:0]  prog_addr = '0, start_addr = '0;
    logic [15:0] prog_wdata = '0, core_busy = '0;
    logic        busy, prog_done;

    task_dispatcher_if #(.INSTR_W(16)) bus();

    task_dispatcher dut (
        .clk        (clk),
        .reset      (reset),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .start      (start),
        .start_addr (start_addr),
        .core_busy  (core_busy),
        .bus        (bus),
        .busy       (busy),
        .prog_done  (prog_done)
    );

    always #5 clk = ~clk;

    logic [15:0] img [MD];
    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 10'(a); prog_wdata = d;
        img[a] = d;
    endtask

    task automatic wr_end();
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic do_start(input int b);
        @(negedge clk);
        start = 1'b1; start_addr = 10'(b);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Accept nw words (optionally with ready toggling) and check each against the image.
    task automatic run_stream(input int b, input int nw, input bit toggle);
        int got = 0, cyc = 0, idx;
        logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [15:0] pd = '0;
        logic [1:0]  pk = '0, ek;
        bus.msg_ready = 1'b1;
        while (got < nw && cyc < 400) begin
            if (toggle && cyc > 0) bus.msg_ready = ~bus.msg_ready;
            if (pv && !pr)
                chk("stall_hold", {13'd0, bus.msg_valid, bus.msg_kind, bus.msg_last, bus.msg_data},
                    {13'd0, 1'b1, pk, pl, pd});
            if (bus.msg_valid && bus.msg_ready) begin
                idx = (b + 1 + got) % MD;
                ek  = (got == 0) ? 2'd0 : (got == 1) ? 2'd1 : (got < 15) ? 2'd2 : 2'd3;
                chk("word_data", 32'(bus.msg_data), 32'(img[idx]));
                chk("word_kind", 32'(bus.msg_kind), 32'(ek));
                chk("word_last", 32'(bus.msg_last), 32'((got % 16) == 14));
                got++;
            end
            pv = bus.msg_valid; pr = bus.msg_ready;
            pd = bus.msg_data;  pk = bus.msg_kind; pl = bus.msg_last;
            if (got < nw) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("word_count", 32'(got), 32'(nw));
        bus.msg_ready = 1'b1;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!prog_done && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("prog_done_pulse", 32'(prog_done), 32'd1);
        @(negedge clk);
        chk("prog_done_clear", 32'(prog_done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        int   k;
        bus.msg_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.msg_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(prog_done), 32'd0);
        chk("rst_data", 32'(bus.msg_data), 32'd0);
        chk("rst_kind", 32'(bus.msg_kind), 32'd0);
        chk("rst_last", 32'(bus.msg_last), 32'd0);
        reset = 1'b0;

        // Background pattern, end bit clear everywhere
        for (int a = 0; a < MD; a++) wr(a, 16'h2800 | 16'(a));
        wr(0, 16'h0002); wr(1, 16'h000F); wr(2, 16'h0003); wr(16'h30, 16'h8000);
        wr_end();

        // Basic task: latency start->CMASK is 3 cycles
        do_start(0);
        chk("lat_fetch_busy", 32'(busy), 32'd1);
        chk("lat_fetch_valid", 32'(bus.msg_valid), 32'd0);
        @(negedge clk);
        chk("lat_wait_valid", 32'(bus.msg_valid), 32'd0);
        @(negedge clk);
        chk("lat_cmask_valid", 32'(bus.msg_valid), 32'd1);
        chk("lat_cmask_data", 32'(bus.msg_data), 32'h000F);
        run_stream(0, 47, 1'b0);
        wait_done();

        // Busy core in mask holds WAIT; a write while busy must be ignored
        core_busy = 16'h0001;
        do_start(0);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 10'd5; prog_wdata = 16'hDEAD;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            prog_we = 1'b0;
            if (bus.msg_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        chk("wait_hold_mask", 32'(bad), 32'd0);
        core_busy = 16'h0000;
        @(negedge clk);
        chk("wait_release_cmask", 32'(bus.msg_data), 32'h000F);
        run_stream(0, 47, 1'b0);
        wait_done();

        // REL fence: busy core outside the mask still blocks; if_num=0 skips INSTR
        wr(16'h100, 16'h0080); wr(16'h101, 16'h00F0); wr(16'h102, 16'h0007);
        wr(16'h110, 16'h8000);
        wr_end();
        core_busy = 16'h0100;
        do_start(16'h100);
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.msg_valid !== 1'b0) bad = 1'b1;
        end
        chk("rel_wait_hold", 32'(bad), 32'd0);
        core_busy = 16'h0000;
        run_stream(16'h100, 15, 1'b0);
        wait_done();

        // ACQ fence: DRAIN holds until masked cores go idle
        wr(16'h200, 16'h0041); wr(16'h201, 16'h0003); wr(16'h202, 16'h0001);
        wr(16'h220, 16'h8000);
        wr_end();
        do_start(16'h200);
        k = 0;
        while (!bus.msg_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        core_busy = 16'h0002;
        run_stream(16'h200, 31, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.msg_valid !== 1'b0 || prog_done !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        chk("acq_drain_hold", 32'(bad), 32'd0);
        core_busy = 16'h0000;
        wait_done();

        // Ready toggling 1010...: hold on stall, nothing dropped or repeated
        do_start(0);
        run_stream(0, 47, 1'b1);
        wait_done();

        // Address wrap: task near top of memory, next header at 0x010
        wr(16'h3F0, 16'h0001); wr(16'h3F1, 16'h0001); wr(16'h3F2, 16'h0000);
        wr(16'h010, 16'h8000);
        wr_end();
        do_start(16'h3F0);
        run_stream(16'h3F0, 31, 1'b0);
        wait_done();

        // Reset mid-R0DATA, then replay from the header
        do_start(0);
        run_stream(0, 5, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", 32'(bus.msg_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_last", 32'(bus.msg_last), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_idle", 32'(bus.msg_valid), 32'd0);
        do_start(0);
        run_stream(0, 47, 1'b0);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
